// File: rtl/toggle_event_rx.sv
// Multi-channel toggle-synchronizer receive side: toggle edges become one-cycle
// pulses, buffered in per-channel pending counters behind a valid/ready handshake.

module toggle_event_lane #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             toggle,
  input  logic             ev_ready,
  input  logic             ovf_clr,
  output logic             ev_pulse,
  output logic             ev_valid,
  output logic [CNT_W-1:0] cnt,
  output logic             overflow
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   push, pop, full, drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], toggle};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign push     = sync[SYNC_STAGES-1] ^ prev;
  assign ev_pulse = push;
  assign ev_valid = (cnt != '0);
  assign pop      = ev_valid & ev_ready;
  assign full     = (cnt == CNT_MAX);
  // A simultaneous pop frees the slot, so push+pop at full is not a drop.
  assign drop     = push & ~pop & full;

  always_ff @(posedge clk) begin
    if (rst)                      cnt <= '0;
    else if (push & ~pop & ~full) cnt <= cnt + CNT_ONE;
    else if (~push & pop)         cnt <= cnt - CNT_ONE;
  end

  // Set beats clear so a drop in the clearing cycle is never hidden.
  always_ff @(posedge clk) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end
endmodule

module toggle_event_rx #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       toggle_in,
  output logic [NUM_CH-1:0]       ev_pulse,
  output logic [NUM_CH-1:0]       ev_valid,
  input  logic [NUM_CH-1:0]       ev_ready,
  output logic [NUM_CH*CNT_W-1:0] pend_cnt,
  output logic [NUM_CH-1:0]       overflow,
  input  logic                    ovf_clr
);
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_arr;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    toggle_event_lane #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .toggle   (toggle_in[g]),
      .ev_ready (ev_ready[g]),
      .ovf_clr  (ovf_clr),
      .ev_pulse (ev_pulse[g]),
      .ev_valid (ev_valid[g]),
      .cnt      (cnt_arr[g]),
      .overflow (overflow[g])
    );
  end

  assign pend_cnt = cnt_arr;
endmodule

// File: tb/tb_toggle_event_rx.sv
// Bench for toggle_event_rx: directed vector table, hand-written corner sequences
// and randomized traffic, all cross-checked every cycle against a sample-history model.

module tb_toggle_event_rx;
  localparam int NUM_CH = 4;
  localparam int S      = 2;
  localparam int CNT_W  = 4;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       toggle_in;
  logic [NUM_CH-1:0]       ev_pulse, ev_valid, ev_ready, overflow;
  logic [NUM_CH*CNT_W-1:0] pend_cnt;
  logic                    ovf_clr;

  toggle_event_rx #(.NUM_CH(NUM_CH), .SYNC_STAGES(S), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .toggle_in(toggle_in), .ev_pulse(ev_pulse),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .pend_cnt(pend_cnt),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference: per channel, the input level seen at each of the last S+1 edges
  // (hist[k] = sample k edges ago) plus an integer pending count and sticky flag.
  bit hist [NUM_CH][S+1];
  int m_pend [NUM_CH];
  bit m_ovf [NUM_CH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit m_pulse(int ch);
    return hist[ch][S-1] ^ hist[ch][S];
  endfunction

  task automatic model_edge(input logic r, input logic [NUM_CH-1:0] tin,
                            input logic [NUM_CH-1:0] rdy, input logic clr);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (r) begin
        for (int k = 0; k <= S; k++) hist[ch][k] = 1'b0;
        m_pend[ch] = 0;
        m_ovf[ch]  = 1'b0;
      end else begin
        bit push, pop, lost;
        push = m_pulse(ch);
        pop  = (m_pend[ch] > 0) && rdy[ch];
        lost = 1'b0;
        if (push && !pop) begin
          if (m_pend[ch] < MAXC) m_pend[ch]++;
          else lost = 1'b1;
        end else if (!push && pop) m_pend[ch]--;
        if (lost) m_ovf[ch] = 1'b1;
        else if (clr) m_ovf[ch] = 1'b0;
        for (int k = S; k > 0; k--) hist[ch][k] = hist[ch][k-1];
        hist[ch][0] = tin[ch];
      end
    end
  endtask

  task automatic step();
    logic r, c;
    logic [NUM_CH-1:0] t, rd, ep, ev, eo;
    logic [NUM_CH*CNT_W-1:0] ec;
    r = rst; c = ovf_clr; t = toggle_in; rd = ev_ready;
    @(posedge clk);
    model_edge(r, t, rd, c);
    #1;
    cyc++;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      ep[ch] = m_pulse(ch);
      ev[ch] = (m_pend[ch] != 0);
      eo[ch] = m_ovf[ch];
      ec[ch*CNT_W +: CNT_W] = m_pend[ch][CNT_W-1:0];
    end
    chk("model_pulse", 64'(ev_pulse), 64'(ep));
    chk("model_valid", 64'(ev_valid), 64'(ev));
    chk("model_cnt",   64'(pend_cnt), 64'(ec));
    chk("model_ovf",   64'(overflow), 64'(eo));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [CNT_W-1:0] cnt_of(int ch);
    return pend_cnt[ch*CNT_W +: CNT_W];
  endfunction

  task automatic toggle_ch(input int ch, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      toggle_in[ch] = ~toggle_in[ch];
      steps(gap);
    end
  endtask

  // Bounded wait for a pulse on channel ch; expiry counts as a failure.
  task automatic wait_pulse(input int ch);
    int n;
    n = 0;
    while (!ev_pulse[ch] && n < 10) begin step(); n++; end
    chk("wait_pulse_timeout", 64'(ev_pulse[ch]), 64'd1);
  endtask

  typedef struct {
    logic rst; logic [3:0] tin; logic [3:0] rdy; logic clr;
    logic [3:0] e_pulse; logic [3:0] e_valid; logic [CNT_W-1:0] e_cnt0; logic [3:0] e_ovf;
  } vec_t;
  vec_t tbl [9];

  int hold [NUM_CH];
  int pct, cnt_hi;

  initial begin
    // Reset and single event on channel 0 (pulse 2 edges after the change).
    tbl[0] = '{1'b1, 4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 4'd0, 4'h0};
    tbl[1] = '{1'b1, 4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 4'd0, 4'h0};
    tbl[2] = '{1'b1, 4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 4'd0, 4'h0};
    tbl[3] = '{1'b0, 4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 4'd0, 4'h0};
    tbl[4] = '{1'b0, 4'h1, 4'hF, 1'b0, 4'h0, 4'h0, 4'd0, 4'h0};
    tbl[5] = '{1'b0, 4'h1, 4'hF, 1'b0, 4'h1, 4'h0, 4'd0, 4'h0};
    tbl[6] = '{1'b0, 4'h1, 4'hF, 1'b0, 4'h0, 4'h1, 4'd1, 4'h0};
    tbl[7] = '{1'b0, 4'h1, 4'hF, 1'b0, 4'h0, 4'h0, 4'd0, 4'h0};
    tbl[8] = '{1'b0, 4'h1, 4'hF, 1'b0, 4'h0, 4'h0, 4'd0, 4'h0};

    rst = 1'b1; toggle_in = '0; ev_ready = '0; ovf_clr = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      for (int k = 0; k <= S; k++) hist[ch][k] = 1'b0;
      m_pend[ch] = 0; m_ovf[ch] = 1'b0;
    end

    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst; toggle_in = tbl[i].tin; ev_ready = tbl[i].rdy; ovf_clr = tbl[i].clr;
      step();
      chk($sformatf("vec%0d_pulse", i), 64'(ev_pulse), 64'(tbl[i].e_pulse));
      chk($sformatf("vec%0d_valid", i), 64'(ev_valid), 64'(tbl[i].e_valid));
      chk($sformatf("vec%0d_cnt0", i),  64'(cnt_of(0)), 64'(tbl[i].e_cnt0));
      chk($sformatf("vec%0d_ovf", i),   64'(overflow), 64'(tbl[i].e_ovf));
    end

    // Backpressure accumulation on channel 1, then drain at one per cycle.
    ev_ready = '0;
    toggle_ch(1, 5, 3);
    steps(3);
    chk("bp_cnt5", 64'(cnt_of(1)), 64'd5);
    ev_ready = 4'b0010;
    cnt_hi = ev_valid[1] ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ev_valid[1]) cnt_hi++;
    end
    chk("bp_valid_cycles", 64'(cnt_hi), 64'd5);
    chk("bp_drained", 64'(cnt_of(1)), 64'd0);

    // Saturation and overflow on channel 2.
    ev_ready = '0;
    toggle_ch(2, 16, 3);
    steps(3);
    chk("sat_cnt15", 64'(cnt_of(2)), 64'd15);
    chk("sat_ovf", 64'(overflow[2]), 64'd1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("clr_ovf", 64'(overflow[2]), 64'd0);
    chk("clr_cnt_kept", 64'(cnt_of(2)), 64'd15);
    toggle_in[2] = ~toggle_in[2];
    wait_pulse(2);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("clr_vs_set", 64'(overflow[2]), 64'd1);
    steps(2);

    // Push and pop together at full: no change, no overflow.
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    toggle_in[2] = ~toggle_in[2];
    wait_pulse(2);
    ev_ready = 4'b0100; step(); ev_ready = '0;
    chk("pushpop_cnt", 64'(cnt_of(2)), 64'd15);
    chk("pushpop_ovf", 64'(overflow[2]), 64'd0);
    steps(2);

    ev_ready = '1; steps(20);

    // Channel independence.
    ev_ready = 4'b0101;
    toggle_in = ~toggle_in;
    steps(6);
    chk("indep_c0", 64'(cnt_of(0)), 64'd0);
    chk("indep_c1", 64'(cnt_of(1)), 64'd1);
    chk("indep_c2", 64'(cnt_of(2)), 64'd0);
    chk("indep_c3", 64'(cnt_of(3)), 64'd1);
    chk("indep_valid", 64'(ev_valid), 64'b1010);

    // Mid-operation reset with channel 3 at 7 pending and overflow set.
    ev_ready = '0;
    toggle_ch(3, 16, 3);
    steps(3);
    ev_ready = 4'b1000; steps(8); ev_ready = '0;
    chk("pre_rst_cnt3", 64'(cnt_of(3)), 64'd7);
    chk("pre_rst_ovf3", 64'(overflow[3]), 64'd1);
    rst = 1'b1; toggle_in = 4'b1000; step(); rst = 1'b0;
    chk("rst_cnt", 64'(pend_cnt), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_valid", 64'(ev_valid), 64'd0);
    chk("rst_pulse", 64'(ev_pulse), 64'd0);
    steps(S - 1);
    chk("post_rst_nopulse", 64'(ev_pulse), 64'd0);
    step();
    chk("post_rst_pulse", 64'(ev_pulse), 64'b1000);
    steps(4);
    chk("post_rst_cnt", 64'(pend_cnt), 64'h1000);

    // Randomized traffic respecting the 2-cycle minimum toggle hold.
    rst = 1'b1; toggle_in = '0; step(); rst = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) hold[ch] = 2;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) pct = $urandom_range(0, 100);
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (hold[ch] >= 2 && $urandom_range(0, 2) == 0) begin
          toggle_in[ch] = ~toggle_in[ch];
          hold[ch] = 0;
        end
        ev_ready[ch] = ($urandom_range(0, 99) < pct);
      end
      ovf_clr = ($urandom_range(0, 99) < 3);
      rst = ($urandom_range(0, 999) < 2);
      if (rst) begin
        toggle_in = '0;
        for (int ch = 0; ch < NUM_CH; ch++) hold[ch] = 0;
      end
      step();
      for (int ch = 0; ch < NUM_CH; ch++) hold[ch]++;
    end
    rst = 1'b0; ovf_clr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
